// File: rtl/rs_enc_parity_gen.sv
// Systematic RS(N_DATA+4, N_DATA) encoder over GF(2^8), poly 0x11D: passes message symbols
// through, then shifts the 4-symbol remainder out of the division LFSR.
module rs_enc_parity_gen #(
   parameter int N_DATA = 24,
   parameter int CNT_W  = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_frame_sync,
   input  logic [7:0] i_data,
   input  logic       i_data_sync,
   output logic [7:0] o_data,
   output logic       o_data_sync,
   output logic       o_parity,
   output logic       o_ready,
   output logic       o_busy,
   output logic       o_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_DATA - 1);

   // Constant operand k folds this into a pure XOR network.
   function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] k);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         acc = acc ^ (sh & {8{k[i]}});
         sh  = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
      end
      return acc;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_b;
   logic [1:0]       pidx_q, pidx_d;
   logic [7:0]       r0_q, r1_q, r2_q, r3_q;
   logic [7:0]       r0_d, r1_d, r2_d, r3_d;
   logic [7:0]       r0_b, r1_b, r2_b, r3_b;
   logic [7:0]       fb_s;
   logic             accept_s;
   logic [7:0]       data_q, data_d;
   logic             dsync_q, dsync_d;
   logic             par_q, par_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   // A frame sync clears the LFSR in the same cycle, so a coincident symbol starts the new frame.
   assign r0_b     = i_frame_sync ? 8'h00 : r0_q;
   assign r1_b     = i_frame_sync ? 8'h00 : r1_q;
   assign r2_b     = i_frame_sync ? 8'h00 : r2_q;
   assign r3_b     = i_frame_sync ? 8'h00 : r3_q;
   assign cnt_b    = i_frame_sync ? {CNT_W{1'b0}} : cnt_q;
   assign fb_s     = i_data ^ r3_b;
   assign accept_s = i_data_sync & (i_frame_sync | (state_q == ST_DATA));

   // Next-state, LFSR update and next output values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pidx_d  = pidx_q;
      r0_d    = r0_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      r3_d    = r3_q;
      data_d  = 8'h00;
      dsync_d = 1'b0;
      par_d   = 1'b0;
      rdy_d   = 1'b0;
      busy_d  = 1'b0;
      err_d   = err_q;

      if (i_frame_sync) begin
         state_d = ST_DATA;
         cnt_d   = {CNT_W{1'b0}};
         pidx_d  = 2'd0;
         r0_d    = 8'h00;
         r1_d    = 8'h00;
         r2_d    = 8'h00;
         r3_d    = 8'h00;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            ST_PARITY: begin
               data_d  = r3_q;
               dsync_d = 1'b1;
               par_d   = 1'b1;
               busy_d  = 1'b1;
               r3_d    = r2_q;
               r2_d    = r1_q;
               r1_d    = r0_q;
               r0_d    = 8'h00;
               pidx_d  = pidx_q + 2'd1;
               err_d   = err_q | i_data_sync;
               if (pidx_q == 2'd3) begin
                  rdy_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_PARITY;
               end
            end
            ST_IDLE, ST_DATA: begin
               state_d = state_q;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (accept_s) begin
         r3_d    = r2_b ^ gf_mul_const(fb_s, 8'h0F);
         r2_d    = r1_b ^ gf_mul_const(fb_s, 8'h36);
         r1_d    = r0_b ^ gf_mul_const(fb_s, 8'h78);
         r0_d    = gf_mul_const(fb_s, 8'h40);
         cnt_d   = cnt_b + CNT_W'(1);
         data_d  = i_data;
         dsync_d = 1'b1;
         state_d = (cnt_b == LAST_IDX) ? ST_PARITY : ST_DATA;
      end else begin
         dsync_d = dsync_d;
      end
   end

   // State, LFSR and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         pidx_q  <= 2'd0;
         r0_q    <= 8'h00;
         r1_q    <= 8'h00;
         r2_q    <= 8'h00;
         r3_q    <= 8'h00;
         data_q  <= 8'h00;
         dsync_q <= 1'b0;
         par_q   <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pidx_q  <= pidx_d;
         r0_q    <= r0_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         r3_q    <= r3_d;
         data_q  <= data_d;
         dsync_q <= dsync_d;
         par_q   <= par_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign o_data      = data_q;
   assign o_data_sync = dsync_q;
   assign o_parity    = par_q;
   assign o_ready     = rdy_q;
   assign o_busy      = busy_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_rs_enc_parity_gen.sv
// Directed bench for rs_enc_parity_gen: hand-computed parity vectors, syndrome checks on
// captured codewords, error/abort/reset cases, and an N_DATA=28 instance.
module tb_rs_enc_parity_gen;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_frame_sync;
   logic [7:0] i_data;
   logic       i_data_sync;
   logic       sel;
   logic       fs1, fs2;

   logic [7:0] d1_data, d2_data, m_data;
   logic       d1_sync, d1_par, d1_rdy, d1_busy, d1_err;
   logic       d2_sync, d2_par, d2_rdy, d2_busy, d2_err;
   logic       m_sync, m_par, m_rdy, m_busy, m_err;

   typedef struct {
      logic [7:0] d;
      logic       par;
      logic       rdy;
      logic       busy;
      int         cyc;
   } cap_t;

   cap_t       cap_q[$];
   cap_t       cap_e;
   logic [7:0] msg [0:31];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;

   always #5 clk = ~clk;

   assign fs1 = i_frame_sync & ~sel;
   assign fs2 = i_frame_sync & sel;

   rs_enc_parity_gen #(.N_DATA(24), .CNT_W(8)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_frame_sync(fs1), .i_data(i_data), .i_data_sync(i_data_sync),
      .o_data(d1_data), .o_data_sync(d1_sync), .o_parity(d1_par), .o_ready(d1_rdy),
      .o_busy(d1_busy), .o_err(d1_err)
   );

   rs_enc_parity_gen #(.N_DATA(28), .CNT_W(8)) dut28 (
      .i_clk(clk), .i_rst(i_rst), .i_frame_sync(fs2), .i_data(i_data), .i_data_sync(i_data_sync),
      .o_data(d2_data), .o_data_sync(d2_sync), .o_parity(d2_par), .o_ready(d2_rdy),
      .o_busy(d2_busy), .o_err(d2_err)
   );

   assign m_data = sel ? d2_data : d1_data;
   assign m_sync = sel ? d2_sync : d1_sync;
   assign m_par  = sel ? d2_par  : d1_par;
   assign m_rdy  = sel ? d2_rdy  : d1_rdy;
   assign m_busy = sel ? d2_busy : d1_busy;
   assign m_err  = sel ? d2_err  : d1_err;

   // Cycle counter used to prove contiguity of output symbols.
   always @(posedge clk) cyc <= cyc + 1;

   // Capture every valid output symbol of the selected instance.
   always @(negedge clk) begin
      if (m_sync) begin
         cap_e.d    = m_data;
         cap_e.par  = m_par;
         cap_e.rdy  = m_rdy;
         cap_e.busy = m_busy;
         cap_e.cyc  = cyc;
         cap_q.push_back(cap_e);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Decoder-side syndromes S_j = c(alpha^j), first symbol = highest power.
   task automatic check_syndromes(input int len);
      logic [7:0] a, s;
      a = 8'h01;
      for (int j = 0; j < 4; j++) begin
         s = 8'h00;
         for (int i = 0; i < len; i++) s = gmul(s, a) ^ cap_q[i].d;
         check_eq($sformatf("syndrome_S%0d", j), {24'd0, s}, 32'd0);
         a = gmul(a, 8'h02);
      end
   endtask

   task automatic send_frame(input int n, input bit gaps, input int tail, input bit fs_first);
      int first;
      if (fs_first) begin
         i_frame_sync = 1'b1;
         i_data       = msg[0];
         i_data_sync  = 1'b1;
         tick();
         first = 1;
      end else begin
         i_frame_sync = 1'b1;
         i_data_sync  = 1'b0;
         tick();
         first = 0;
         check_eq("fs_quiet", {29'd0, m_sync, m_par, m_busy}, 32'd0);
      end
      i_frame_sync = 1'b0;
      cap_q.delete();
      for (int i = first; i < n; i++) begin
         i_data      = msg[i];
         i_data_sync = 1'b1;
         tick();
         if (gaps && (i % 3 == 1)) begin
            i_data_sync = 1'b0;
            i_data      = 8'hA5;
            tick();
            tick();
         end
      end
      for (int t = 0; t < tail; t++) begin
         i_data      = 8'hFF;
         i_data_sync = 1'b1;
         tick();
      end
      i_data_sync = 1'b0;
      i_data      = 8'h00;
      repeat (8) tick();
   endtask

   task automatic verify_frame(input int n, input bit gaps, input bit chk_par,
                               input logic [31:0] par_exp, input bit chk_syn);
      check_eq("cw_len", cap_q.size(), n + 4);
      if (cap_q.size() == n + 4) begin
         for (int i = 0; i < n; i++)
            check_eq($sformatf("data%0d", i), {23'd0, cap_q[i].par, cap_q[i].d}, {24'd0, msg[i]});
         for (int j = 0; j < 4; j++) begin
            check_eq($sformatf("par%0d_flags", j),
                     {29'd0, cap_q[n+j].par, cap_q[n+j].busy, cap_q[n+j].rdy},
                     {29'd0, 1'b1, 1'b1, (j == 3)});
            check_eq($sformatf("par%0d_contig", j), cap_q[n+j].cyc, cap_q[n-1].cyc + j + 1);
            if (chk_par)
               check_eq($sformatf("par%0d_val", j), {24'd0, cap_q[n+j].d}, {24'd0, par_exp[31-8*j -: 8]});
         end
         if (!gaps) check_eq("cw_span", cap_q[n+3].cyc - cap_q[0].cyc, n + 3);
         if (chk_syn) check_syndromes(n + 4);
      end
      check_eq("idle_after", {20'd0, m_data, m_sync, m_par, m_busy, m_rdy}, 32'd0);
   endtask

   initial begin
      i_rst        = 1'b1;
      i_frame_sync = 1'b0;
      i_data_sync  = 1'b0;
      i_data       = 8'h00;
      sel          = 1'b0;
      repeat (3) tick();
      check_eq("rst_outs", {d1_data, d1_sync, d1_par, d1_rdy, d1_busy, d1_err}, 32'd0);
      check_eq("rst_outs28", {d2_data, d2_sync, d2_par, d2_rdy, d2_busy, d2_err}, 32'd0);
      i_rst = 1'b0;

      // Strobes in IDLE are ignored.
      cap_q.delete();
      i_data = 8'h33; i_data_sync = 1'b1;
      repeat (3) tick();
      i_data_sync = 1'b0;
      tick();
      check_eq("idle_ignore", cap_q.size(), 0);
      check_eq("idle_err", {31'd0, m_err}, 32'd0);

      for (int i = 0; i < 32; i++) msg[i] = 8'h00;
      send_frame(24, 1'b0, 0, 1'b0);
      verify_frame(24, 1'b0, 1'b1, 32'h00000000, 1'b0);
      check_eq("zero_err", {31'd0, m_err}, 32'd0);

      msg[23] = 8'h01;
      send_frame(24, 1'b0, 0, 1'b0);
      verify_frame(24, 1'b0, 1'b1, 32'h0F367840, 1'b1);

      msg[23] = 8'h02;
      send_frame(24, 1'b0, 0, 1'b0);
      verify_frame(24, 1'b0, 1'b1, 32'h1E6CF080, 1'b1);

      for (int i = 0; i < 24; i++) msg[i] = 8'(i * 37 + 11);
      send_frame(24, 1'b1, 0, 1'b1);
      verify_frame(24, 1'b1, 1'b0, 32'h0, 1'b1);

      // Strobes during PARITY are dropped and flag o_err.
      for (int i = 0; i < 32; i++) msg[i] = 8'h00;
      msg[23] = 8'h01;
      send_frame(24, 1'b0, 2, 1'b0);
      verify_frame(24, 1'b0, 1'b1, 32'h0F367840, 1'b0);
      check_eq("err_set", {31'd0, m_err}, 32'd1);
      repeat (3) tick();
      check_eq("err_held", {31'd0, m_err}, 32'd1);
      i_frame_sync = 1'b1;
      tick();
      i_frame_sync = 1'b0;
      check_eq("err_clear", {31'd0, m_err}, 32'd0);

      // Abort after 10 symbols, then a fresh frame.
      for (int i = 0; i < 10; i++) begin
         i_data = 8'h5A; i_data_sync = 1'b1; tick();
      end
      i_data_sync = 1'b0;
      send_frame(24, 1'b0, 0, 1'b0);
      verify_frame(24, 1'b0, 1'b1, 32'h0F367840, 1'b1);

      // Frame sync on the 2nd parity cycle aborts the remaining parity.
      i_frame_sync = 1'b1; tick(); i_frame_sync = 1'b0;
      for (int i = 0; i < 24; i++) begin
         i_data = 8'h77; i_data_sync = 1'b1; tick();
      end
      i_data_sync = 1'b0;
      tick();
      check_eq("abort_p1", {30'd0, m_par, m_busy}, 32'd3);
      msg[23] = 8'h00;
      msg[22] = 8'h01;
      send_frame(24, 1'b0, 0, 1'b0);
      verify_frame(24, 1'b0, 1'b1, 32'h6357D2E7, 1'b1);

      // Reset mid-DATA.
      i_frame_sync = 1'b1; tick(); i_frame_sync = 1'b0;
      for (int i = 0; i < 5; i++) begin
         i_data = 8'h11; i_data_sync = 1'b1; tick();
      end
      i_rst = 1'b1;
      tick();
      check_eq("rst_mid_data", {d1_data, d1_sync, d1_par, d1_rdy, d1_busy, d1_err}, 32'd0);
      i_rst = 1'b0;
      cap_q.delete();
      repeat (4) tick();
      i_data_sync = 1'b0;
      repeat (6) tick();
      check_eq("rst_data_silent", cap_q.size(), 0);

      // Reset mid-PARITY.
      i_frame_sync = 1'b1; tick(); i_frame_sync = 1'b0;
      for (int i = 0; i < 24; i++) begin
         i_data = 8'h22; i_data_sync = 1'b1; tick();
      end
      i_data_sync = 1'b0;
      tick();
      i_rst = 1'b1;
      tick();
      check_eq("rst_mid_par", {d1_data, d1_sync, d1_par, d1_rdy, d1_busy, d1_err}, 32'd0);
      i_rst = 1'b0;
      cap_q.delete();
      i_data_sync = 1'b1;
      repeat (4) tick();
      i_data_sync = 1'b0;
      repeat (6) tick();
      check_eq("rst_par_silent", cap_q.size(), 0);
      check_eq("rst_par_err", {31'd0, m_err}, 32'd0);

      // N_DATA=28 instance with the single-0x01 vector.
      sel = 1'b1;
      for (int i = 0; i < 32; i++) msg[i] = 8'h00;
      msg[27] = 8'h01;
      send_frame(28, 1'b0, 0, 1'b0);
      verify_frame(28, 1'b0, 1'b1, 32'h0F367840, 1'b1);
      sel = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rs_enc_parity_gen.md
Name: rs_enc_parity_gen

Overview:
Systematic Reed-Solomon parity generator over GF(2^8), the transmit-side counterpart of the CD syndrome/Euclid decoder chain. It accepts a frame of N_DATA message symbols, passes them through, then appends 4 parity symbols. The output is a codeword that yields all-zero syndromes S0..S3 at the decoder.
- Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
- Generator: g(x) = (x+1)(x+a)(x+a^2)(x+a^3) = x^4 + 0x0F x^3 + 0x36 x^2 + 0x78 x + 0x40.

Parameters:
N_DATA, 24, message symbols per frame (24 = C2 RS(28,24); 28 = C1 RS(32,28)); legal range 1..251
CNT_W, 8, width of the symbol counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, synchronous, active-high
i_frame_sync  in  1  one-cycle pulse that starts a new frame (clears the LFSR)
i_data  in  8  message symbol
i_data_sync  in  1  i_data valid strobe
o_data  out  8  codeword symbol (message pass-through, then parity)
o_data_sync  out  1  o_data valid
o_parity  out  1  high while o_data carries a parity symbol
o_ready  out  1  one-cycle pulse with the last parity symbol
o_busy  out  1  high while the block is emitting parity (input not accepted)
o_err  out  1  sticky; set when a data strobe is dropped, cleared by i_frame_sync or reset

Behaviour:
- Reset (i_rst=1 at a clock edge) takes priority over everything.
  - Registers: state=IDLE, counter=0, LFSR r0..r3=0.
  - Outputs: o_data=0x00, o_data_sync=0, o_parity=0, o_ready=0, o_busy=0, o_err=0.
  - Reset mid-frame aborts the frame with no further output.
- States:
  - IDLE: data strobes are ignored; o_err is not set.
  - i_frame_sync (any state, no reset): clear r0..r3, clear counter and o_err, go to DATA. Any parity emission in progress is aborted; o_busy drops next cycle.
  - If i_frame_sync and i_data_sync occur in the same cycle, that symbol is the first symbol of the new frame.
- DATA: each cycle with i_data_sync=1:
  - f = i_data ^ r3
  - r3 <= r2 ^ 0x0F*f; r2 <= r1 ^ 0x36*f; r1 <= r0 ^ 0x78*f; r0 <= 0x40*f
  - Multiplies are GF(2^8) constant multiplies (combinational XOR networks, no tables).
  - Counter increments on each accepted symbol.
  - Cycles without a strobe leave the state unchanged; gaps are allowed.
  - When the N_DATA-th symbol is accepted, go to PARITY.
- Output timing:
  - Outputs are registered. Accepted symbol k appears on o_data with o_data_sync=1 and o_parity=0 exactly 1 cycle later.
  - PARITY lasts 4 consecutive cycles and emits r3, r2, r1, r0 in that order, with o_data_sync=1, o_parity=1 and o_busy=1.
  - The first parity symbol appears the cycle after the last data symbol is output, so the codeword is contiguous when input was contiguous.
  - Parity is shifted out of the LFSR; no separate copy is kept.
  - o_ready=1 together with r0 (4th parity symbol). The next state is IDLE.
- Data strobes during PARITY are dropped and set o_err.
- Outside valid cycles, o_data holds 0x00 and o_data_sync=0.
- Latency: last input symbol to o_ready = 5 cycles when input is contiguous.
- Widths: the counter saturates logically at N_DATA and never wraps within a frame. CNT_W must satisfy 2^CNT_W > N_DATA.

Test Plan:
- Reset then frame_sync, 24 contiguous 0x00 symbols -> 24 zero outputs, then parity 0x00,0x00,0x00,0x00; o_ready pulses on the 28th output cycle; o_err=0.
- 23 x 0x00 then 0x01 -> parity 0x0F,0x36,0x78,0x40 (remainder of x^4 mod g); o_parity high on exactly 4 cycles.
- Random 24-symbol frames with random gaps on i_data_sync -> output codeword is 28 contiguous-valid symbols; a reference GF model and the decoder syndrome block both report S0..S3 = 0x00; 1000 frames.
- Strobe i_data_sync during the PARITY cycles -> symbol dropped, o_err=1 and held; parity values unchanged; next i_frame_sync clears o_err.
- i_frame_sync after 10 symbols, then a fresh 24-symbol frame -> parity equals the fresh-frame model. Also assert i_frame_sync coincident with the 2nd parity cycle -> remaining parity suppressed, new frame correct.
- Assert i_rst mid-DATA and mid-PARITY -> all outputs 0 next cycle; strobes without a following i_frame_sync produce no output. Repeat with N_DATA=28 and the single-0x01 vector -> parity 0x0F,0x36,0x78,0x40.
